// File: rtl/wshb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller.
// Grants per cyc envelope; a watchdog terminates stalled strobes with err.
module wshb_arbiter_2m #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [ADR_W-1:0]   m0_adr,
    input  logic [DAT_W-1:0]   m0_dat_ms,
    input  logic [DAT_W/8-1:0] m0_sel,
    input  logic [2:0]         m0_cti,
    input  logic [1:0]         m0_bte,
    output logic [DAT_W-1:0]   m0_dat_sm,
    output logic               m0_ack,
    output logic               m0_err,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [ADR_W-1:0]   m1_adr,
    input  logic [DAT_W-1:0]   m1_dat_ms,
    input  logic [DAT_W/8-1:0] m1_sel,
    input  logic [2:0]         m1_cti,
    input  logic [1:0]         m1_bte,
    output logic [DAT_W-1:0]   m1_dat_sm,
    output logic               m1_ack,
    output logic               m1_err,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [ADR_W-1:0]   s_adr,
    output logic [DAT_W-1:0]   s_dat_ms,
    output logic [DAT_W/8-1:0] s_sel,
    output logic [2:0]         s_cti,
    output logic [1:0]         s_bte,
    input  logic [DAT_W-1:0]   s_dat_sm,
    input  logic               s_ack,
    output logic [1:0]         gnt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_last_gnt;
    logic [CW-1:0] r_wd_cnt;
    logic          w_own_stb;
    logic          w_stall;
    logic          w_expire;

    assign w_own_stb = (r_state == GNT0) ? m0_stb :
                       (r_state == GNT1) ? m1_stb : 1'b0;
    assign w_stall   = w_own_stb & ~s_ack;
    // An ack in the expiry cycle suppresses the timeout since w_stall drops
    assign w_expire  = (TIMEOUT > 0) && w_stall && (r_wd_cnt == WD_LIM);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (m0_cyc && m1_cyc)
                    w_next = r_last_gnt ? GNT0 : GNT1;
                else if (m0_cyc)
                    w_next = GNT0;
                else if (m1_cyc)
                    w_next = GNT1;
            end
            GNT0: if (!m0_cyc) w_next = m1_cyc ? GNT1 : IDLE;
            GNT1: if (!m1_cyc) w_next = m0_cyc ? GNT0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_wd_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != IDLE && w_next != r_state)
                r_last_gnt <= (r_state == GNT1);
            if (TIMEOUT == 0 || w_next != r_state || w_expire || !w_stall)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        s_cti     = '0;
        s_bte     = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m0_dat_sm = '0;
        m1_dat_sm = '0;
        gnt       = 2'b00;
        unique case (r_state)
            GNT0: begin
                gnt       = 2'b01;
                s_cyc     = m0_cyc;
                s_stb     = m0_stb & ~w_expire;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_dat_ms  = m0_dat_ms;
                s_sel     = m0_sel;
                s_cti     = m0_cti;
                s_bte     = m0_bte;
                m0_ack    = s_ack & ~w_expire;
                m0_err    = w_expire;
                m0_dat_sm = s_dat_sm;
                m1_dat_sm = s_dat_sm;
            end
            GNT1: begin
                gnt       = 2'b10;
                s_cyc     = m1_cyc;
                s_stb     = m1_stb & ~w_expire;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_dat_ms  = m1_dat_ms;
                s_sel     = m1_sel;
                s_cti     = m1_cti;
                s_bte     = m1_bte;
                m1_ack    = s_ack & ~w_expire;
                m1_err    = w_expire;
                m0_dat_sm = s_dat_sm;
                m1_dat_sm = s_dat_sm;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Randomized bench for wshb_arbiter_2m against an ownership/stall-count model.
// A second instance with the watchdog disabled shares all stimulus.
module tb_wshb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_ms;
    logic [SW-1:0] m0_sel;
    logic [2:0]    m0_cti;
    logic [1:0]    m0_bte;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_ms;
    logic [SW-1:0] m1_sel;
    logic [2:0]    m1_cti;
    logic [1:0]    m1_bte;
    logic [DW-1:0] s_dat_sm;
    logic          s_ack;

    logic [DW-1:0] m0_dat_sm, m1_dat_sm;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_ms;
    logic [SW-1:0] s_sel;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [1:0]    gnt;

    logic [DW-1:0] z_m0_dat_sm, z_m1_dat_sm;
    logic          z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
    logic          z_s_cyc, z_s_stb, z_s_we;
    logic [AW-1:0] z_s_adr;
    logic [DW-1:0] z_s_dat_ms;
    logic [SW-1:0] z_s_sel;
    logic [2:0]    z_s_cti;
    logic [1:0]    z_s_bte;
    logic [1:0]    z_gnt;

    always #5 clk = ~clk;

    wshb_arbiter_2m #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti),
        .m0_bte(m0_bte), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
        .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti),
        .m1_bte(m1_bte), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
        .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .gnt(gnt)
    );

    wshb_arbiter_2m #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti),
        .m0_bte(m0_bte), .m0_dat_sm(z_m0_dat_sm), .m0_ack(z_m0_ack),
        .m0_err(z_m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti),
        .m1_bte(m1_bte), .m1_dat_sm(z_m1_dat_sm), .m1_ack(z_m1_ack),
        .m1_err(z_m1_err),
        .s_cyc(z_s_cyc), .s_stb(z_s_stb), .s_we(z_s_we), .s_adr(z_s_adr),
        .s_dat_ms(z_s_dat_ms), .s_sel(z_s_sel), .s_cti(z_s_cti),
        .s_bte(z_s_bte), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .gnt(z_gnt)
    );

    int n_chk = 0;
    int n_err = 0;

    // model: owner 0 = none, 1 = m0, 2 = m1; stall = consecutive stalled cycles
    int own   = 0;
    int last  = 1;
    int stall = 0;

    int n_ack0 = 0;
    int n_ack1 = 0;
    int n_err1 = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit stalled();
        if (own == 1) return m0_stb && !s_ack;
        if (own == 2) return m1_stb && !s_ack;
        return 1'b0;
    endfunction

    function automatic bit expired();
        return stalled() && (stall + 1 == TO);
    endfunction

    task automatic cmp();
        logic          ecyc, estb, ewe, ex;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat, erd;
        logic [SW-1:0] esel;
        logic [2:0]    ecti;
        logic [1:0]    ebte, eack, eerr, eg;
        ecyc = 0; estb = 0; ewe = 0; eadr = '0; edat = '0; esel = '0;
        ecti = '0; ebte = '0; eack = '0; eerr = '0; erd = '0; eg = '0;
        ex = expired();
        if (own == 1) begin
            eg = 2'b01; ecyc = m0_cyc; estb = m0_stb && !ex; ewe = m0_we;
            eadr = m0_adr; edat = m0_dat_ms; esel = m0_sel;
            ecti = m0_cti; ebte = m0_bte;
        end else if (own == 2) begin
            eg = 2'b10; ecyc = m1_cyc; estb = m1_stb && !ex; ewe = m1_we;
            eadr = m1_adr; edat = m1_dat_ms; esel = m1_sel;
            ecti = m1_cti; ebte = m1_bte;
        end
        if (own != 0) begin
            eack[own-1] = s_ack;
            eerr[own-1] = ex;
            erd = s_dat_sm;
        end
        check("gnt", gnt, eg);
        check("s_cyc", s_cyc, ecyc);
        check("s_stb", s_stb, estb);
        check("s_we", s_we, ewe);
        check("s_adr", s_adr, eadr);
        check("s_dat_ms", s_dat_ms, edat);
        check("s_sel", s_sel, esel);
        check("s_cti", s_cti, ecti);
        check("s_bte", s_bte, ebte);
        check("acks", {m1_ack, m0_ack}, eack);
        check("errs", {m1_err, m0_err}, eerr);
        check("m0_dat_sm", m0_dat_sm, erd);
        check("m1_dat_sm", m1_dat_sm, erd);
        check("wd0_err", {z_m1_err, z_m0_err}, 2'b00);
        n_ack0 += int'(m0_ack);
        n_ack1 += int'(m1_ack);
        n_err1 += int'(m1_err);
    endtask

    task automatic upd();
        bit c0, c1, ex;
        c0 = m0_cyc; c1 = m1_cyc; ex = expired();
        if (own == 0) begin
            if (c0 && c1) own = (last == 1) ? 1 : 2;
            else if (c0)  own = 1;
            else if (c1)  own = 2;
            stall = 0;
        end else if (!(own == 1 ? c0 : c1)) begin
            last  = own - 1;
            own   = (own == 1) ? (c1 ? 2 : 0) : (c0 ? 1 : 0);
            stall = 0;
        end else if (stalled() && !ex) begin
            stall++;
        end else begin
            stall = 0;
        end
    endtask

    task automatic step();
        #1;
        cmp();
        @(posedge clk);
        upd();
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0;
        m0_sel = '0; m0_cti = '0; m0_bte = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0;
        m1_sel = '0; m1_cti = '0; m1_bte = '0;
        s_ack = 0;
    endtask

    task automatic rand_inputs(input int ackp, input bit stb_full);
        if ($urandom_range(9) == 0) m0_cyc = ~m0_cyc;
        if ($urandom_range(9) == 0) m1_cyc = ~m1_cyc;
        m0_stb = m0_cyc && (stb_full || $urandom_range(3) != 0);
        m1_stb = m1_cyc && (stb_full || $urandom_range(3) != 0);
        m0_we = 1'($urandom); m1_we = 1'($urandom);
        m0_adr = $urandom; m1_adr = $urandom;
        m0_dat_ms = $urandom; m1_dat_ms = $urandom;
        m0_sel = SW'($urandom); m1_sel = SW'($urandom);
        m0_cti = 3'($urandom); m1_cti = 3'($urandom);
        m0_bte = 2'($urandom); m1_bte = 2'($urandom);
        s_dat_sm = $urandom;
        s_ack = ($urandom_range(99) < ackp);
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        s_dat_sm = 32'hDEAD_BEEF;
        #2;
        check("rst_gnt", gnt, 2'b00);
        check("rst_s_cyc", {s_cyc, s_stb}, 2'b00);
        check("rst_dat_sm", m0_dat_sm, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // only m0 requests
        m0_cyc = 1; m0_stb = 1; m0_we = 1;
        m0_adr = 32'h100; m0_dat_ms = 32'hFF_FFFF;
        step();
        @(negedge clk);
        step();
        check("m0_only_gnt", gnt, 2'b01);
        check("m0_only_adr", s_adr, 32'h100);
        @(negedge clk);
        step();
        @(negedge clk);
        s_ack = 1;
        step();
        check("m0_only_ack", {m1_ack, m0_ack}, 2'b01);
        @(negedge clk);
        s_ack = 0;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        step();
        // m0 drops for one cycle then re-requests: m1 must own until it drops
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        step();
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1;
        step();
        check("rr_m1", gnt, 2'b10);
        repeat (6) begin
            @(negedge clk);
            s_ack = 1'($urandom);
            step();
            check("rr_hold", gnt, 2'b10);
        end
        @(negedge clk);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        step();
        @(negedge clk);
        step();
        check("rr_back_m0", gnt, 2'b01);

        // watchdog: m1 stalls with no ack
        @(negedge clk);
        idle_inputs();
        step();
        @(negedge clk);
        step();
        n_err1 = 0; n_ack1 = 0;
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        repeat (41) begin
            step();
            @(negedge clk);
        end
        check("wd_pulses", n_err1, 2);
        check("wd_no_ack", n_ack1, 0);

        // async reset while m0 is strobing
        idle_inputs();
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1;
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        #1;
        check("pre_rst_gnt", gnt, 2'b01);
        rst_n = 0;
        #1;
        check("arst_s", {s_cyc, s_stb}, 2'b00);
        check("arst_gnt", gnt, 2'b00);
        own = 0; last = 1; stall = 0;
        m1_cyc = 1; m1_stb = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
        @(negedge clk);
        step();
        check("tie_m0", gnt, 2'b01);
        repeat (8) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        step();
        @(negedge clk);
        step();
        check("switch_m1", gnt, 2'b10);
        check("switch_adr", s_adr, m1_adr);

        // ack isolation: m0 burst of 64 acks while m1 holds cyc
        @(negedge clk);
        idle_inputs();
        step();
        @(negedge clk);
        m0_cyc = 1;
        step();
        @(negedge clk);
        m1_cyc = 1; m0_stb = 1; s_ack = 1;
        n_ack0 = 0; n_ack1 = 0;
        repeat (64) begin
            step();
            @(negedge clk);
        end
        check("iso_m0_acks", n_ack0, 64);
        check("iso_m1_acks", n_ack1, 0);
        idle_inputs();
        step();

        // randomized traffic, then long-stall traffic
        repeat (1500) begin
            @(negedge clk);
            rand_inputs(50, 1'b0);
            step();
        end
        repeat (3600) begin
            @(negedge clk);
            rand_inputs(3, 1'b1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
